// File: rtl/pipe_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, bubble word and
// the IF/ID latch bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr = nop;
        b.pc4   = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory read port,
// IF/ID latch outputs and status/performance counters.
interface fetch_controller_if #(
    parameter int IMEM_AW = 10
);
    logic                stall;
    logic                redirect;
    logic [31:0]         redirect_target;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [31:0]         imem_data;
    logic [31:0]         pc;
    logic [31:0]         if_id_instr;
    logic [31:0]         if_id_pc4;
    logic                if_id_valid;
    logic                halted;
    logic                addr_err;
    logic [31:0]         fetch_count;
    logic [15:0]         stall_count;

    modport master (
        input  stall, redirect, redirect_target, imem_data,
        output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               halted, addr_err, fetch_count, stall_count
    );

    modport slave (
        output stall, redirect, redirect_target, imem_data,
        input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               halted, addr_err, fetch_count, stall_count
    );
endinterface

// File: rtl/fetch_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end
endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, loads the IF/ID latch, and handles
// stalls, redirects with flush, end-of-program halt and fetch/stall counters.
//
//   state | meaning
//   BOOT  | one cycle after reset, IF/ID holds a bubble, pc = 0
//   RUN   | fetching: redirect > stall > sequential fetch
//   HALT  | last word fetched or bad target; bubbles only, wait for redirect
module fetch_controller
    import pipe_pkg::*;
#(
    parameter int                 IMEM_AW   = 10,
    parameter logic [IMEM_AW-1:0] LAST_ADDR = 10'h100,
    parameter logic [31:0]        NOP_WORD  = pipe_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master bus
);
    localparam logic [31:0] LAST_PC = 32'(LAST_ADDR);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    if_id_t       if_id, if_id_nxt;
    logic         err, err_nxt;
    logic         fetch_inc, stall_inc;

    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;
    logic         target_misaligned;
    logic         target_out_of_range;
    if_id_t       bubble;
    if_id_t       fetched;

    assign pc_plus4            = pc + 32'd4;
    assign target_aligned      = {bus.redirect_target[31:2], 2'b00};
    assign target_misaligned   = |bus.redirect_target[1:0];
    assign target_out_of_range = |bus.redirect_target[31:IMEM_AW];
    assign bubble              = if_id_bubble(NOP_WORD);

    always_comb begin
        fetched.instr = bus.imem_data;
        fetched.pc4   = pc_plus4;
        fetched.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= '0;
            if_id <= bubble;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if_id <= if_id_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if_id_nxt = if_id;
        err_nxt   = err;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        case (state)
            BOOT: begin
                if_id_nxt = bubble;
                pc_nxt    = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (bus.redirect) begin
                    if_id_nxt = bubble;
                    if (target_out_of_range) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt  = target_aligned;
                        err_nxt = err | target_misaligned;
                    end
                end else if (bus.stall) begin
                    stall_inc = 1'b1;
                end else begin
                    if_id_nxt = fetched;
                    fetch_inc = 1'b1;
                    if (pc == LAST_PC)
                        state_nxt = HALT;
                    else
                        pc_nxt = pc_plus4;
                end
            end
            HALT: begin
                if_id_nxt = bubble;
                // A branch resolved after the halting fetch may still pull us back.
                if (bus.redirect) begin
                    if (target_out_of_range) begin
                        err_nxt = 1'b1;
                    end else begin
                        pc_nxt    = target_aligned;
                        err_nxt   = err | target_misaligned;
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    sat_counter #(.WIDTH(32)) u_fetch_count (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (fetch_inc),
        .count (bus.fetch_count)
    );

    sat_counter #(.WIDTH(16)) u_stall_count (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    assign bus.pc          = pc;
    assign bus.imem_addr   = pc[IMEM_AW-1:0];
    assign bus.if_id_instr = if_id.instr;
    assign bus.if_id_pc4   = if_id.pc4;
    assign bus.if_id_valid = if_id.valid;
    assign bus.halted      = (state == HALT);
    assign bus.addr_err    = err;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: free-run fetch, then a vector table of
// stall/redirect/halt/error cases, then mid-run reset and out-of-range target.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic reset;

    fetch_controller_if #(.IMEM_AW(10)) bus ();

    fetch_controller #(
        .IMEM_AW   (10),
        .LAST_ADDR (10'h100),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        case (a)
            10'h000: return 32'h8C01_0000;
            10'h004: return 32'h8C02_0004;
            10'h0E0: return 32'hAC0A_007C;
            default: return {16'h2000, 6'b0, a};
        endcase
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        err;
        logic [31:0] fc;
        logic [15:0] sc;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        exp_t        e;
    } vec_t;

    int applied = 0;
    int miscompares = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid,
                                input logic halted, input logic err,
                                input logic [31:0] fc, input logic [15:0] sc);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4; e.valid = valid;
        e.halted = halted; e.err = err; e.fc = fc; e.sc = sc;
        return e;
    endfunction

    function automatic vec_t mv(input logic stall, input logic redirect,
                                input logic [31:0] target, input exp_t e);
        vec_t v;
        v.stall = stall; v.redirect = redirect; v.target = target; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input exp_t e);
        logic bad;
        bad = 1'b0;
        applied++;
        if (bus.pc !== e.pc) begin
            $display("FAIL %s pc got %h want %h", name, bus.pc, e.pc); bad = 1'b1;
        end
        if (bus.imem_addr !== e.pc[9:0]) begin
            $display("FAIL %s imem_addr got %h want %h", name, bus.imem_addr, e.pc[9:0]); bad = 1'b1;
        end
        if (bus.if_id_instr !== e.instr) begin
            $display("FAIL %s if_id_instr got %h want %h", name, bus.if_id_instr, e.instr); bad = 1'b1;
        end
        if (bus.if_id_pc4 !== e.pc4) begin
            $display("FAIL %s if_id_pc4 got %h want %h", name, bus.if_id_pc4, e.pc4); bad = 1'b1;
        end
        if (bus.if_id_valid !== e.valid) begin
            $display("FAIL %s if_id_valid got %b want %b", name, bus.if_id_valid, e.valid); bad = 1'b1;
        end
        if (bus.halted !== e.halted) begin
            $display("FAIL %s halted got %b want %b", name, bus.halted, e.halted); bad = 1'b1;
        end
        if (bus.addr_err !== e.err) begin
            $display("FAIL %s addr_err got %b want %b", name, bus.addr_err, e.err); bad = 1'b1;
        end
        if (bus.fetch_count !== e.fc) begin
            $display("FAIL %s fetch_count got %0d want %0d", name, bus.fetch_count, e.fc); bad = 1'b1;
        end
        if (bus.stall_count !== e.sc) begin
            $display("FAIL %s stall_count got %0d want %0d", name, bus.stall_count, e.sc); bad = 1'b1;
        end
        if (bad) miscompares++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [16];
    exp_t reset_e;

    initial begin
        reset_e = mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);

        // Starting at pc=0xBC after 47 sequential fetches.
        tbl[0]  = mv(1'b1, 1'b0, 32'h0,   mk(32'hBC,  rom_word(10'hB8),  32'hBC,  1'b1, 1'b0, 1'b0, 32'd47, 16'd1));
        tbl[1]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hC0,  rom_word(10'hBC),  32'hC0,  1'b1, 1'b0, 1'b0, 32'd48, 16'd1));
        tbl[2]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hC4,  rom_word(10'hC0),  32'hC4,  1'b1, 1'b0, 1'b0, 32'd49, 16'd1));
        tbl[3]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hC8,  rom_word(10'hC4),  32'hC8,  1'b1, 1'b0, 1'b0, 32'd50, 16'd1));
        tbl[4]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hCC,  rom_word(10'hC8),  32'hCC,  1'b1, 1'b0, 1'b0, 32'd51, 16'd1));
        tbl[5]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hD0,  rom_word(10'hCC),  32'hD0,  1'b1, 1'b0, 1'b0, 32'd52, 16'd1));
        tbl[6]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hD4,  rom_word(10'hD0),  32'hD4,  1'b1, 1'b0, 1'b0, 32'd53, 16'd1));
        tbl[7]  = mv(1'b0, 1'b1, 32'hE0,  mk(32'hE0,  32'h0,             32'h0,   1'b0, 1'b0, 1'b0, 32'd53, 16'd1));
        tbl[8]  = mv(1'b0, 1'b0, 32'h0,   mk(32'hE4,  32'hAC0A_007C,     32'hE4,  1'b1, 1'b0, 1'b0, 32'd54, 16'd1));
        tbl[9]  = mv(1'b1, 1'b1, 32'h100, mk(32'h100, 32'h0,             32'h0,   1'b0, 1'b0, 1'b0, 32'd54, 16'd1));
        tbl[10] = mv(1'b0, 1'b0, 32'h0,   mk(32'h100, rom_word(10'h100), 32'h104, 1'b1, 1'b1, 1'b0, 32'd55, 16'd1));
        tbl[11] = mv(1'b1, 1'b0, 32'h0,   mk(32'h100, 32'h0,             32'h0,   1'b0, 1'b1, 1'b0, 32'd55, 16'd1));
        tbl[12] = mv(1'b0, 1'b1, 32'hE4,  mk(32'hE4,  32'h0,             32'h0,   1'b0, 1'b0, 1'b0, 32'd55, 16'd1));
        tbl[13] = mv(1'b0, 1'b0, 32'h0,   mk(32'hE8,  rom_word(10'hE4),  32'hE8,  1'b1, 1'b0, 1'b0, 32'd56, 16'd1));
        tbl[14] = mv(1'b0, 1'b1, 32'h102, mk(32'h100, 32'h0,             32'h0,   1'b0, 1'b0, 1'b1, 32'd56, 16'd1));
        tbl[15] = mv(1'b0, 1'b0, 32'h0,   mk(32'h100, rom_word(10'h100), 32'h104, 1'b1, 1'b1, 1'b1, 32'd57, 16'd1));

        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;
        reset = 1'b1;
        #1;
        check("reset", reset_e);

        @(negedge clk);
        reset = 1'b0;
        tick();
        check("boot", reset_e);

        for (int i = 0; i < 47; i++) begin
            tick();
            check($sformatf("run%0d", i),
                  mk(32'(4 * (i + 1)), rom_word(10'(4 * i)), 32'(4 * (i + 1)),
                     1'b1, 1'b0, 1'b0, 32'(i + 1), 16'd0));
        end

        for (int k = 0; k < 16; k++) begin
            bus.stall = tbl[k].stall;
            bus.redirect = tbl[k].redirect;
            bus.redirect_target = tbl[k].target;
            tick();
            check($sformatf("vec%0d", k), tbl[k].e);
        end
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;

        // Reset while halted with nonzero counters and sticky error.
        reset = 1'b1;
        #2;
        check("reset_halt", reset_e);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rerun", mk(32'h8, rom_word(10'h4), 32'h8, 1'b1, 1'b0, 1'b0, 32'd2, 16'd0));

        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b1;
        #1;
        check("reset_midrun", reset_e);
        #2;
        reset = 1'b0;
        tick();
        check("boot2", reset_e);
        tick();
        check("fetch2", mk(32'h4, 32'h8C01_0000, 32'h4, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0));

        bus.redirect = 1'b1;
        bus.redirect_target = 32'h400;
        tick();
        check("range_err", mk(32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd1, 16'd0));
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;
        bus.stall = 1'b1;
        tick();
        check("range_hold", mk(32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd1, 16'd0));
        bus.stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
